// File: rtl/dfd_apb_req_master.sv
`default_nettype none
// ============================================================================
//  Module   : dfd_apb_req_master
//  Purpose  : APB4 requester for the DFD register slave port. Register
//             read/write requests arrive on a valid/ready port and are queued
//             in order. They are issued one APB transfer at a time. The read
//             data and error status are returned on a valid/ready response
//             port.
//  Ports    : clk, reset            - clock, asynchronous active-high reset
//             req_*                 - request port (valid/ready, write, addr,
//                                     wdata, strb)
//             rsp_*                 - response port (valid/ready, rdata, err,
//                                     timeout)
//             busy                  - queue non-empty or a transfer in flight
//             paddr..pstrb          - APB master outputs
//             pready/prdata/pslverr - APB slave returns
//  Revision : 1.0  initial release
// ============================================================================
module dfd_apb_req_master #(
  parameter int ADDR_W      = 23,
  parameter int DATA_W      = 32,
  parameter int STRB_W      = DATA_W / 8,
  parameter int REQ_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_strb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  output logic [STRB_W-1:0] pstrb,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pslverr
);

  localparam int PTR_W = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int ENT_W = 1 + ADDR_W + DATA_W + STRB_W;
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [PTR_W:0]   c_depth    = (PTR_W + 1)'(REQ_DEPTH);
  localparam logic             c_to_en    = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] c_to_last  = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [CNT_W-1:0] c_cnt_max  = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Request FIFO
  // --------------------------------------------------------------------------
  logic [ENT_W-1:0] fifo_mem [REQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             fifo_push, fifo_pop, fifo_empty, fifo_full;

  logic              head_write;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;
  logic [STRB_W-1:0] head_strb;

  // Full is taken from the registered count, so a pop in the same cycle
  // never opens room for a push until the following cycle.
  assign fifo_full  = (count_q == c_depth);
  assign fifo_empty = (count_q == '0);
  assign req_ready  = ~fifo_full;
  assign fifo_push  = req_valid & ~fifo_full;

  assign {head_write, head_addr, head_wdata, head_strb} = fifo_mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr_q] <= {req_write, req_addr, req_wdata, req_strb};
    end
  end

  always_comb begin
    wr_ptr_d = fifo_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = fifo_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + (PTR_W + 1)'(fifo_push) - (PTR_W + 1)'(fifo_pop);
  end

  // --------------------------------------------------------------------------
  // Transfer FSM
  // --------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0] pstrb_q, pstrb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              tout_q, tout_d;
  logic              load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tout_q   <= tout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    cnt_d    = '0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tout_d   = tout_q;
    load     = 1'b0;
    fifo_pop = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        cnt_d = cnt_q;
        if (pready) begin
          rdata_d = pwrite_q ? '0 : prdata;
          err_d   = pslverr;
          tout_d  = 1'b0;
          state_d = ST_RESP;
        end else if (c_to_en && (cnt_q == c_to_last)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          tout_d  = 1'b1;
          state_d = ST_RESP;
        end else if (cnt_q != c_cnt_max) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          if (!fifo_empty) load = 1'b1;
          else             state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Loading the head both starts SETUP and pops the entry in one edge.
    if (load) begin
      state_d  = ST_SETUP;
      fifo_pop = 1'b1;
      paddr_d  = head_addr;
      pwrite_d = head_write;
      pwdata_d = head_wdata;
      pstrb_d  = head_write ? head_strb : '0;
    end
  end

  assign psel        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable     = (state_q == ST_ACCESS);
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  // Strobes are only driven while the bus is selected.
  assign pstrb       = psel ? pstrb_q : '0;
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = tout_q;
  assign busy        = ~fifo_empty || (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dfd_apb_req_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dfd_apb_req_master
//  Purpose  : Self-checking bench for dfd_apb_req_master. A behavioural APB
//             slave with per-transfer wait/error/hang plans, an in-order
//             response model and directed plus randomized request sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dfd_apb_req_master;

  localparam int AW = 23;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_strb;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err, rsp_timeout, busy;
  logic [AW-1:0] paddr;
  logic          psel, penable, pwrite;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          pslverr;

  always #5 clk = ~clk;

  dfd_apb_req_master #(
    .ADDR_W(AW), .DATA_W(DW), .STRB_W(SW), .REQ_DEPTH(4), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata),
    .pslverr(pslverr)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    int            waits;
    bit            err;
    bit            hang;
  } xfer_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tout;
  } rsp_t;

  xfer_t         prm_q[$];
  rsp_t          exp_q[$];
  logic [DW-1:0] mdl_mem [logic [AW-1:0]];
  logic [DW-1:0] slv_mem [logic [AW-1:0]];

  int n_cmp  = 0;
  int n_fail = 0;
  int n_rsp  = 0;
  int rdy_mode = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {a[7:0], 1'b1, a};
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                          input logic [SW-1:0] s);
    logic [DW-1:0] r;
    r = o;
    for (int b = 0; b < SW; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] mdl_rd(input logic [AW-1:0] a);
    return mdl_mem.exists(a) ? mdl_mem[a] : init_val(a);
  endfunction

  function automatic logic [DW-1:0] slv_rd(input logic [AW-1:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : init_val(a);
  endfunction

  function automatic xfer_t mk(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [SW-1:0] s, input int w, input bit e, input bit h);
    xfer_t x;
    x.wr = wr; x.addr = a; x.wdata = d; x.strb = s; x.waits = w; x.err = e; x.hang = h;
    return x;
  endfunction

  // ---------------- behavioural APB slave ----------------
  xfer_t slv_cur;
  bit    slv_active = 1'b0;
  int    slv_wc = 0;

  initial begin
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    forever begin
      @(posedge clk); #1;
      pready = 1'b0; pslverr = 1'b0;
      if (psel && penable) begin
        if (!slv_active) begin
          slv_active = 1'b1;
          slv_wc = 0;
          chk("slave_plan_available", 64'(prm_q.size() > 0), 64'd1);
          if (prm_q.size() > 0) slv_cur = prm_q.pop_front();
          else slv_cur = mk(1'b0, '0, '0, '0, 0, 1'b0, 1'b1);
          chk("apb_paddr", 64'(paddr), 64'(slv_cur.addr));
          chk("apb_pwrite", 64'(pwrite), 64'(slv_cur.wr));
          chk("apb_pstrb", 64'(pstrb), slv_cur.wr ? 64'(slv_cur.strb) : 64'd0);
          if (slv_cur.wr) chk("apb_pwdata", 64'(pwdata), 64'(slv_cur.wdata));
        end
        if (!slv_cur.hang && slv_wc == slv_cur.waits) begin
          pready  = 1'b1;
          pslverr = slv_cur.err;
          prdata  = pwrite ? DW'($urandom) : slv_rd(paddr);
          if (pwrite && !slv_cur.err) slv_mem[paddr] = merge(slv_rd(paddr), pwdata, pstrb);
          slv_active = 1'b0;
        end else begin
          slv_wc++;
        end
      end else begin
        slv_active = 1'b0;
      end
    end
  end

  // ---------------- response consumer drive ----------------
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      rsp_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!reset && rsp_valid && rsp_ready) begin
        n_rsp++;
        chk("rsp_was_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          chk("rsp_timeout", 64'(rsp_timeout), 64'(e.tout));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_phase();
    @(posedge clk); #1;
  endtask

  // Caller must be at posedge+1. Returns at posedge+1 after the last try.
  task automatic push(input xfer_t x, input int max_cyc, output bit acc);
    rsp_t r;
    acc = 1'b0;
    req_valid = 1'b1; req_write = x.wr; req_addr = x.addr;
    req_wdata = x.wdata; req_strb = x.strb;
    for (int i = 0; i < max_cyc && !acc; i++) begin
      @(negedge clk);
      if (req_ready) acc = 1'b1;
      drive_phase();
    end
    req_valid = 1'b0;
    if (acc) begin
      if (x.hang) begin
        r.rdata = '0; r.err = 1'b1; r.tout = 1'b1;
      end else if (x.wr) begin
        r.rdata = '0; r.err = x.err; r.tout = 1'b0;
        if (!x.err) mdl_mem[x.addr] = merge(mdl_rd(x.addr), x.wdata, x.strb);
      end else begin
        r.rdata = mdl_rd(x.addr); r.err = x.err; r.tout = 1'b0;
      end
      prm_q.push_back(x);
      exp_q.push_back(r);
    end
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int i;
    i = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && i < max_cyc) begin
      @(negedge clk);
      i++;
    end
    @(negedge clk);
    chk({tag, "_busy_clear"}, 64'(busy), 64'd0);
    chk({tag, "_all_responses"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic count_access(output int pen, output logic [SW-1:0] so, output bit done);
    pen = 0; so = '0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (penable) pen++;
      if (psel) so = so | pstrb;
      if (rsp_valid) done = 1'b1;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit            acc;
    int            n_acc, pen, base;
    logic [SW-1:0] so;
    bit            done;
    xfer_t         x;

    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_psel", 64'(psel), 64'd0);
    chk("reset_penable", 64'(penable), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_paddr", 64'(paddr), 64'd0);
    chk("reset_pstrb", 64'(pstrb), 64'd0);
    chk("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
    reset = 1'b0;

    // 1: zero-wait write, latency check
    rdy_mode = 1;
    drive_phase();
    push(mk(1'b1, 23'h000248, 32'hDEADBEEF, 4'hF, 0, 1'b0, 1'b0), 10, acc);
    chk("t1_accepted", 64'(acc), 64'd1);
    @(negedge clk);
    chk("t1_psel_n0", 64'(psel), 64'd0);
    chk("t1_busy_n0", 64'(busy), 64'd1);
    @(negedge clk);
    chk("t1_psel_n1", 64'(psel), 64'd1);
    chk("t1_penable_n1", 64'(penable), 64'd0);
    @(negedge clk);
    chk("t1_psel_n2", 64'(psel), 64'd1);
    chk("t1_penable_n2", 64'(penable), 64'd1);
    @(negedge clk);
    chk("t1_rsp_valid_n3", 64'(rsp_valid), 64'd1);
    chk("t1_psel_n3", 64'(psel), 64'd0);
    wait_idle("t1", 50);

    // 2: read with three wait states
    drive_phase();
    push(mk(1'b0, 23'h000248, '0, 4'hF, 3, 1'b0, 1'b0), 10, acc);
    count_access(pen, so, done);
    chk("t2_rsp_seen", 64'(done), 64'd1);
    chk("t2_penable_cycles", 64'(pen), 64'd4);
    chk("t2_pstrb_read", 64'(so), 64'd0);
    wait_idle("t2", 50);

    // 3: back-pressure; six tries, five accepted, in-order drain
    rdy_mode = 0;
    drive_phase();
    base = n_rsp;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      push(mk(1'b0, AW'(i * 4), '0, '0, 0, 1'b0, 1'b0), 1, acc);
      if (acc) n_acc++;
    end
    chk("t3_accepted_count", 64'(n_acc), 64'd5);
    @(negedge clk);
    chk("t3_req_ready_full", 64'(req_ready), 64'd0);
    chk("t3_rsp_held", 64'(rsp_valid), 64'd1);
    rdy_mode = 1;
    wait_idle("t3", 100);
    chk("t3_response_count", 64'(n_rsp - base), 64'd5);

    // 4: timeout with pready stuck low
    drive_phase();
    push(mk(1'b0, 23'h000030, '0, '0, 0, 1'b0, 1'b1), 10, acc);
    count_access(pen, so, done);
    chk("t4_rsp_seen", 64'(done), 64'd1);
    chk("t4_access_cycles", 64'(pen), 64'd8);
    wait_idle("t4", 50);

    // 5: slave error on write, then a normal read of the same address
    drive_phase();
    push(mk(1'b1, 23'h166040, 32'hBEEFDEAD, 4'hF, 0, 1'b1, 1'b0), 20, acc);
    push(mk(1'b0, 23'h166040, '0, '0, 1, 1'b0, 1'b0), 20, acc);
    wait_idle("t5", 50);

    // random traffic
    rdy_mode = 2;
    drive_phase();
    for (int i = 0; i < 40; i++) begin
      x = mk(1'($urandom_range(0, 1)), AW'(23'h100 + 4 * $urandom_range(0, 3)), DW'($urandom),
             SW'($urandom), int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 15) == 0));
      push(x, 200, acc);
      chk("rnd_accepted", 64'(acc), 64'd1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) drive_phase();
    end
    rdy_mode = 1;
    wait_idle("rnd", 2000);

    // 6: asynchronous reset during ACCESS with two queued
    drive_phase();
    for (int i = 0; i < 3; i++) push(mk(1'b0, AW'(23'h200 + 4 * i), '0, '0, 6, 1'b0, 1'b0), 5, acc);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (penable) done = 1'b1;
    end
    chk("t6_reached_access", 64'(done), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_psel_async", 64'(psel), 64'd0);
    chk("t6_penable_async", 64'(penable), 64'd0);
    prm_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base = n_rsp;
    repeat (4) begin
      @(negedge clk);
      chk("t6_req_ready", 64'(req_ready), 64'd1);
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    end
    chk("t6_no_response", 64'(n_rsp - base), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
